game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_ctrl.sv | 151 +++++++++++++++
 tb/tb_game_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// game_ctrl: snake game controller with IDLE/RUN/DEAD FSM, step timer, heading, score and best score.
// Optional macro GAME_CTRL_SPEEDUP_EN shortens the step period as the score grows.
module game_ctrl #(
  parameter int unsigned TICK_DIV = 5_000_000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        start,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        collision,
  input  logic        food,
  output logic        step,
  output logic [1:0]  dir,
  output logic [1:0]  state,
  output logic [19:0] score,
  output logic [19:0] high_score
);

  localparam int CW = 26;
  localparam logic [19:0] SCORE_MAX = 20'd999_999;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DEAD = 2'd2,
    S_BAD  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dir_q, dir_d;
  logic [1:0]    pend_q, pend_d;
  logic [19:0]   score_q, score_d;
  logic [19:0]   high_q, high_d;
  logic          at_last;
  logic          req_valid;
  logic [1:0]    req_dir;

`ifdef GAME_CTRL_SPEEDUP_EN
  localparam logic [CW-1:0] DIV_FULL  = CW'(TICK_DIV);
  localparam logic [CW-1:0] DIV_FLOOR = CW'(TICK_DIV / 4);
  localparam logic [CW-1:0] DIV_CUT   = CW'(TICK_DIV / 16);
  localparam logic [43:0]   CUT_LIMIT = 44'(DIV_FULL - DIV_FLOOR);

  logic [CW-1:0] div_q, div_next;
  logic [43:0]   cut;

  // Period shrinks by TICK_DIV/16 per 8 points, never below a quarter of TICK_DIV.
  always_comb begin
    cut = {27'd0, score_q[19:3]} * {18'd0, DIV_CUT};
    if (cut >= CUT_LIMIT) div_next = DIV_FLOOR;
    else                  div_next = DIV_FULL - cut[CW-1:0];
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset)                                                 div_q <= DIV_FULL;
    else if ((state_q == S_IDLE || state_q == S_DEAD) && start) div_q <= DIV_FULL;
    else if (step)                                              div_q <= div_next;
  end

  assign at_last = (cnt_q >= div_q - CW'(1));
`else
  assign at_last = (cnt_q == CW'(TICK_DIV - 1));
`endif

  // Equal and opposite headings share parity, so a turn is legal only across parity.
  always_comb begin
    req_valid = 1'b0;
    req_dir   = dir_q;
    if (up && dir_q[0]) begin
      req_valid = 1'b1;
      req_dir   = 2'd0;
    end else if (down && dir_q[0]) begin
      req_valid = 1'b1;
      req_dir   = 2'd2;
    end else if (left && !dir_q[0]) begin
      req_valid = 1'b1;
      req_dir   = 2'd3;
    end else if (right && !dir_q[0]) begin
      req_valid = 1'b1;
      req_dir   = 2'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    pend_d  = pend_q;
    score_d = score_q;
    high_d  = high_q;
    step    = 1'b0;
    case (state_q)
      S_IDLE, S_DEAD: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          dir_d   = 2'd1;
          pend_d  = 2'd1;
          score_d = '0;
        end
      end
      S_RUN: begin
        // A collision freezes the game for this cycle: no step, no food credit.
        if (collision) begin
          state_d = S_DEAD;
          cnt_d   = '0;
          if (score_q > high_q) high_d = score_q;
        end else begin
          if (req_valid) pend_d = req_dir;
          if (at_last) begin
            step  = 1'b1;
            cnt_d = '0;
            dir_d = pend_d;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
          if (food && score_q != SCORE_MAX) score_d = score_q + 20'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dir_q   <= 2'd1;
      pend_q  <= 2'd1;
      score_q <= '0;
      high_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      score_q <= score_d;
      high_q  <= high_d;
    end
  end

  assign state      = state_q;
  assign dir        = dir_q;
  assign score      = score_q;
  assign high_score = high_q;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed scenarios plus random play of game_ctrl, checked against a rule-level game model.
`timescale 1ns/1ps
module tb_game_ctrl;

`ifdef GAME_CTRL_SPEEDUP_EN
  localparam int TD = 64;
  localparam bit SPEED = 1'b1;
`else
  localparam int TD = 4;
  localparam bit SPEED = 1'b0;
`endif
  localparam int MAXS = 999_999;
  localparam int BUDGET = 4 * TD + 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic collision = 1'b0, food = 1'b0;
  logic step;
  logic [1:0] dir, state;
  logic [19:0] score, high_score;

  int total = 0, bad = 0;

  // Game model: mode 0 idle / 1 running / 2 dead, cycles since last step, period in effect.
  int m_state, m_ticks, m_div, m_head, m_pend, m_score, m_best;
  int prio_dir [4] = '{0, 2, 3, 1};

  logic       obs_step;
  logic [1:0] obs_dir, obs_state;
  logic [19:0] obs_score, obs_high;

  game_ctrl #(.TICK_DIV(TD)) dut (
    .CLOCK_50(clk), .reset(rst_n), .start(start),
    .up(up), .down(down), .left(left), .right(right),
    .collision(collision), .food(food),
    .step(step), .dir(dir), .state(state),
    .score(score), .high_score(high_score)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int speedDiv(input int s);
    longint d;
    if (!SPEED) return TD;
    d = longint'(TD) - longint'(s / 8) * longint'(TD / 16);
    return (d < TD / 4) ? TD / 4 : int'(d);
  endfunction

  function automatic bit expStep();
    return (m_state == 1) && !collision && (m_ticks + 1 >= m_div);
  endfunction

  task automatic modelReset();
    m_state = 0; m_ticks = 0; m_div = TD;
    m_head = 1; m_pend = 1; m_score = 0; m_best = 0;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic modelEdge();
    bit stp;
    bit req [4];
    stp = expStep();
    req[0] = up; req[1] = down; req[2] = left; req[3] = right;
    if (m_state == 1) begin
      if (collision) begin
        if (m_score > m_best) m_best = m_score;
        m_state = 2;
        m_ticks = 0;
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (req[k] && prio_dir[k] != m_head && prio_dir[k] != (m_head + 2) % 4) begin
            m_pend = prio_dir[k];
            break;
          end
        end
        if (stp) begin
          m_head  = m_pend;
          m_ticks = 0;
          m_div   = speedDiv(m_score);
        end else begin
          m_ticks++;
        end
        if (food && m_score < MAXS) m_score++;
      end
    end else if (start) begin
      m_state = 1; m_score = 0; m_ticks = 0;
      m_head = 1; m_pend = 1; m_div = TD;
    end
  endtask

  task automatic applyStimulus(input bit st, input bit u, input bit d, input bit l,
                               input bit r, input bit col, input bit fd);
    @(negedge clk);
    start = st; up = u; down = d; left = l; right = r; collision = col; food = fd;
    #1;
    obs_step = step; obs_dir = dir; obs_state = state; obs_score = score; obs_high = high_score;
    checkOutput("step", obs_step, expStep());
    checkOutput("state", obs_state, m_state);
    checkOutput("dir", obs_dir, m_head);
    checkOutput("score", obs_score, m_score);
    checkOutput("high", obs_high, m_best);
    modelEdge();
    @(posedge clk);
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    start = 0; up = 0; down = 0; left = 0; right = 0; collision = 0; food = 0;
    #1;
    checkOutput("rstState", state, 0);
    checkOutput("rstStep", step, 0);
    checkOutput("rstDir", dir, 1);
    checkOutput("rstScore", score, 0);
    checkOutput("rstHigh", high_score, 0);
    modelReset();
    start = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rstIgnoresStart", state, 0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic runUntilStep();
    int n = 0;
    do begin
      idle();
      n++;
    end while (!obs_step && n < BUDGET);
    if (!obs_step) checkOutput("stepTimeout", obs_step, 1);
  endtask

  task automatic forceScore(input int s);
    #2;
    force dut.score_q = 20'(s);
    #1;
    release dut.score_q;
    m_score = s;
  endtask

  task automatic measurePeriod(input string tag, input int exp);
    int n = 0;
    runUntilStep();
    do begin
      idle();
      n++;
    end while (!obs_step && n < BUDGET);
    checkOutput(tag, n, exp);
  endtask

  initial begin
    modelReset();
    doReset();
    idle();
    idle();

    // Start from IDLE, then steps every TD cycles heading right.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      idle();
      checkOutput("runState", obs_state, 1);
      checkOutput("stepAt", obs_step, (i % TD) == 0);
      checkOutput("dirRight", obs_dir, 1);
    end

    // Reversal is ignored, a later legal request is taken at the next step.
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    runUntilStep();
    idle();
    checkOutput("turnUp", obs_dir, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    runUntilStep();
    idle();
    checkOutput("turnLeft", obs_dir, 3);
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    runUntilStep();
    idle();
    checkOutput("upOverDown", obs_dir, 0);

    // Five foods, die, restart keeps the best score.
    for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    idle();
    checkOutput("deadState", obs_state, 2);
    checkOutput("deadScore", obs_score, 5);
    checkOutput("deadHigh", obs_high, 5);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    idle();
    checkOutput("restartState", obs_state, 1);
    checkOutput("restartScore", obs_score, 0);
    checkOutput("restartHigh", obs_high, 5);

    // Food and collision together on a step cycle: collision wins.
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 0, 0, 1);
    for (int n = 0; n < BUDGET && m_ticks + 1 < m_div; n++) idle();
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    checkOutput("colNoStep", obs_step, 0);
    idle();
    checkOutput("colScore", obs_score, 3);
    checkOutput("colHigh", obs_high, 3);
    checkOutput("colState", obs_state, 2);

    // Score saturates at the top of its range.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    forceScore(MAXS - 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    idle();
    checkOutput("satScore", obs_score, MAXS);

`ifdef GAME_CTRL_SPEEDUP_EN
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    measurePeriod("period0", 64);
    forceScore(8);
    measurePeriod("period8", 60);
    forceScore(96);
    measurePeriod("period96", 16);
`endif

    // Random play with occasional mid-game resets.
    doReset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) doReset();
      applyStimulus($urandom_range(0, 19) == 0,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
